sha_mem_host: RTL and testbench

- Host-side companion and memory responder for the simplified SHA-256 engine.
- Owns a word-addressed SRAM and answers the engine's memory port: mem_addr, mem_we and mem_write_data in, mem_read_data out.
- Streams NUM_OF_WORDS message words from a valid/ready input into memory, then pulses the engine's start.
- Waits for the engine's done, then streams the 8 hash words back out over a valid/ready output.

---
 rtl/sha_mem_host.sv | 200 ++++++++++++++++++++
 tb/tb_sha_mem_host.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_mem_host.sv
// rtl/sha_mem_host.sv - SRAM owner and job sequencer for the SHA-256 engine (option: SHA_MEM_TIMEOUT_EN)
module sha_mem_host #(
  parameter int          NUM_OF_WORDS   = 20,
  parameter int          DEPTH          = 512,
  parameter logic [15:0] MSG_BASE       = 16'h0000,
  parameter logic [15:0] OUT_BASE       = 16'h0100,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        error,
  output logic        sha_start,
  input  logic        sha_done,
  output logic [15:0] sha_message_addr,
  output logic [15:0] sha_output_addr,
  input  logic [15:0] mem_addr,
  input  logic        mem_we,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data
);

  localparam logic [2:0] S_LOAD      = 3'd0;
  localparam logic [2:0] S_KICK      = 3'd1;
  localparam logic [2:0] S_WAIT_ACK  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_DRAIN_RD  = 3'd4;
  localparam logic [2:0] S_DRAIN_OUT = 3'd5;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(NUM_OF_WORDS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_OF_WORDS - 1);

  // Every job address must land inside the SRAM, and the watchdog limit must fit its 16-bit counter.
  if ((32'(MSG_BASE) + NUM_OF_WORDS > DEPTH) || (32'(OUT_BASE) + 8 > DEPTH)) begin : g_bad_addr
    $error("sha_mem_host: job addresses exceed DEPTH");
  end
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("sha_mem_host: TIMEOUT_CYCLES out of range");
  end

  logic [31:0]   mem [DEPTH];

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          in_ready_q, sha_start_q, out_valid_q, out_last_q, busy_q;
  logic [31:0]   out_data_q, mem_read_data_q;

  logic          engine_owns, in_hs, timeout_hit;
  logic          wr_en;
  logic [15:0]   wr_addr, rd_addr;
  logic [31:0]   wr_data, rd_data;

  function automatic logic in_range(input logic [15:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  assign engine_owns = (state_q == S_KICK) || (state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE);
  assign in_hs       = (state_q == S_LOAD) && in_ready_q && in_valid;

  assign rd_addr = engine_owns ? mem_addr : (OUT_BASE + 16'(idx_q));
  assign rd_data = in_range(rd_addr) ? mem[rd_addr[AW-1:0]] : 32'd0;

  // Single write port: host message words in LOAD, engine writes only while it owns the SRAM.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = MSG_BASE + 16'(cnt_q);
    wr_data = in_data;
    if (in_hs) begin
      wr_en = 1'b1;
    end else if (engine_owns && mem_we) begin
      wr_en   = 1'b1;
      wr_addr = mem_addr;
      wr_data = mem_write_data;
    end
  end

  // SRAM array; contents survive reset, out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && in_range(wr_addr)) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // Job sequencer: load, kick, wait for engine, drain the hash.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      S_LOAD: begin
        if (in_hs) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = S_KICK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_KICK: state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!sha_done) state_d = S_WAIT_DONE;
        else if (timeout_hit) state_d = S_LOAD;
      end
      S_WAIT_DONE: begin
        if (sha_done) begin
          state_d = S_DRAIN_RD;
          idx_d   = 3'd0;
        end else if (timeout_hit) begin
          state_d = S_LOAD;
        end
      end
      S_DRAIN_RD: state_d = S_DRAIN_OUT;
      S_DRAIN_OUT: begin
        if (out_ready) begin
          if (idx_q == 3'd7) begin
            state_d = S_LOAD;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_DRAIN_RD;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_LOAD;
      cnt_q           <= '0;
      idx_q           <= 3'd0;
      in_ready_q      <= 1'b0;
      sha_start_q     <= 1'b0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      busy_q          <= 1'b0;
      out_data_q      <= 32'd0;
      mem_read_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      in_ready_q  <= (state_d == S_LOAD);
      sha_start_q <= (state_d == S_KICK);
      out_valid_q <= (state_d == S_DRAIN_OUT);
      out_last_q  <= (state_d == S_DRAIN_OUT) && (idx_d == 3'd7);
      busy_q      <= !((state_d == S_LOAD) && (cnt_d == '0));
      if (state_q == S_DRAIN_RD) out_data_q <= rd_data;
      if (engine_owns) mem_read_data_q <= rd_data;
    end
  end

`ifdef SHA_MEM_TIMEOUT_EN
  logic        in_wait;
  logic [15:0] timer_q;
  logic        error_q;

  assign in_wait     = (state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE);
  assign timeout_hit = in_wait && (timer_q == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog over the engine wait states; error sticks until the next accepted message word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= 16'd0;
      error_q <= 1'b0;
    end else begin
      timer_q <= in_wait ? (timer_q + 16'd1) : 16'd0;
      if (timeout_hit && (state_d == S_LOAD)) error_q <= 1'b1;
      else if (in_hs) error_q <= 1'b0;
    end
  end

  assign error = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  assign in_ready         = in_ready_q;
  assign sha_start        = sha_start_q;
  assign out_valid        = out_valid_q;
  assign out_last         = out_last_q;
  assign out_data         = out_data_q;
  assign busy             = busy_q;
  assign mem_read_data    = mem_read_data_q;
  assign sha_message_addr = MSG_BASE;
  assign sha_output_addr  = OUT_BASE;

endmodule

// File: tb/tb_sha_mem_host.sv
// tb/tb_sha_mem_host.sv - scoreboard bench for sha_mem_host
module tb_sha_mem_host;

  localparam int NW = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        error;
  logic        sha_start;
  logic        sha_done = 1'b1;
  logic [15:0] sha_message_addr;
  logic [15:0] sha_output_addr;
  logic [15:0] mem_addr = 16'd0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_write_data = 32'd0;
  logic [31:0] mem_read_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  sha_mem_host #(
    .NUM_OF_WORDS(NW), .DEPTH(512), .MSG_BASE(16'h0000), .OUT_BASE(16'h0100), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .error(error), .sha_start(sha_start), .sha_done(sha_done),
    .sha_message_addr(sha_message_addr), .sha_output_addr(sha_output_addr),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_job(input logic [31:0] base, input bit hammer);
    int n = 0;
    int cyc = 0;
    while (n < NW && cyc < 200) begin
      @(negedge clk);
      cyc++;
      in_valid       = 1'b1;
      in_data        = base + 32'(n);
      mem_we         = hammer && (n < NW - 1);
      mem_addr       = 16'h0000;
      mem_write_data = 32'hFFFF_FFFF;
      if (in_ready) n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    mem_we   = 1'b0;
    check_eq("load_cycles", cyc, NW);
    check_eq("in_ready_after_load", in_ready, 1'b0);
    check_eq("sha_start_pulse", sha_start, 1'b1);
    check_eq("busy_after_load", busy, 1'b1);
    @(negedge clk);
    check_eq("sha_start_one_cycle", sha_start, 1'b0);
  endtask

  task automatic eng_read(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    mem_addr = addr;
    mem_we   = 1'b0;
    @(negedge clk);
    check_eq(tag, mem_read_data, exp);
  endtask

  task automatic eng_write(input logic [15:0] addr, input logic [31:0] data, input bit last);
    mem_addr       = addr;
    mem_write_data = data;
    mem_we         = 1'b1;
    exp_q.push_back({last, data});
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic drain(input int stop_after, input bit toggle);
    int got = 0;
    int cyc = 0;
    bit rdy = 1'b1;
    bit stalled = 1'b0;
    logic [31:0] held = 32'd0;
    logic [32:0] e;
    while (got < stop_after && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", out_data, 32'hxxxx_xxxx);
          out_ready = 1'b0;
          got = stop_after;
        end else begin
          e = exp_q[0];
          if (stalled) check_eq("hold_data", out_data, held);
          check_eq("out_last", out_last, e[32]);
          if (rdy) begin
            out_ready = 1'b1;
            check_eq("out_data", out_data, e[31:0]);
            void'(exp_q.pop_front());
            got++;
            stalled = 1'b0;
          end else begin
            out_ready = 1'b0;
            held      = out_data;
            stalled   = 1'b1;
          end
          if (toggle) rdy = !rdy;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    check_eq("drain_count", got, stop_after);
  endtask

  initial begin
    int vcnt;
    int cyc;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_error", error, 1'b0);
    check_eq("rst_sha_start", sha_start, 1'b0);
    check_eq("rst_mem_read_data", mem_read_data, 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("msg_addr", sha_message_addr, 16'h0000);
    check_eq("out_addr", sha_output_addr, 16'h0100);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("idle_in_ready", in_ready, 1'b1);
    check_eq("idle_busy", busy, 1'b0);

    // job 1: load, engine reads/writes, long done wait, stalled drain
    load_job(32'h0000_0001, 1'b0);
    sha_done = 1'b0;
    @(negedge clk);
    eng_read("eng_rd_3", 16'h0003, 32'h0000_0004);
    eng_read("eng_rd_oob", 16'h0200, 32'h0000_0000);
    eng_read("eng_rd_19", 16'h0013, 32'h0000_0014);
    for (int k = 0; k < 8; k++) eng_write(16'h0100 + 16'(k), 32'hDEAD_BEE0 + 32'(k), k == 7);
    vcnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    check_eq("no_out_while_busy", vcnt, 0);
    check_eq("busy_in_wait", busy, 1'b1);
    sha_done = 1'b1;
    drain(8, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("job1_out_valid_end", out_valid, 1'b0);
    check_eq("job1_busy_end", busy, 1'b0);
    check_eq("job1_in_ready_end", in_ready, 1'b1);

    // job 2: engine hammers address 0 during LOAD, read-during-write, reset mid-drain
    load_job(32'h0000_0100, 1'b1);
    sha_done = 1'b0;
    @(negedge clk);
    eng_read("arb_rd_0", 16'h0000, 32'h0000_0100);
    eng_read("job2_rd_3", 16'h0003, 32'h0000_0103);
    mem_addr       = 16'h0100;
    mem_write_data = 32'h1234_5678;
    mem_we         = 1'b1;
    exp_q.push_back({1'b0, 32'h1234_5678});
    @(negedge clk);
    mem_we = 1'b0;
    check_eq("rd_old_on_write", mem_read_data, 32'hDEAD_BEE0);
    @(negedge clk);
    check_eq("rd_new_after_write", mem_read_data, 32'h1234_5678);
    for (int k = 1; k < 8; k++) eng_write(16'h0100 + 16'(k), 32'hA5A5_0000 + 32'(k), k == 7);
    sha_done = 1'b1;
    drain(3, 1'b0);
    cyc = 0;
    do begin
      @(negedge clk);
      out_ready = 1'b0;
      cyc++;
    end while (!out_valid && cyc < 10);
    check_eq("idx3_valid", out_valid, 1'b1);
    check_eq("idx3_data", out_data, 32'hA5A5_0003);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 1'b0);
    check_eq("mid_rst_sha_start", sha_start, 1'b0);
    check_eq("mid_rst_in_ready", in_ready, 1'b0);
    check_eq("mid_rst_busy", busy, 1'b0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1'b1);
    check_eq("post_rst_out_valid", out_valid, 1'b0);

    // job 3: fresh load; engine writes nothing, so the retained SRAM hash drains
    load_job(32'h0000_0200, 1'b0);
    sha_done = 1'b0;
    @(negedge clk);
    eng_read("job3_rd_0", 16'h0000, 32'h0000_0200);
    exp_q.push_back({1'b0, 32'h1234_5678});
    for (int k = 1; k < 8; k++) exp_q.push_back({k == 7, 32'hA5A5_0000 + 32'(k)});
    sha_done = 1'b1;
    drain(8, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("job3_busy_end", busy, 1'b0);
    check_eq("job3_in_ready_end", in_ready, 1'b1);
    check_eq("error_low", error, 1'b0);

`ifdef SHA_MEM_TIMEOUT_EN
    // timeout: engine never acknowledges start
    load_job(32'h0000_0300, 1'b0);
    cyc  = 0;
    vcnt = 0;
    while (!error && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (out_valid) vcnt++;
    end
    check_eq("timeout_cycles", cyc, 100);
    check_eq("timeout_error", error, 1'b1);
    check_eq("timeout_in_ready", in_ready, 1'b1);
    check_eq("timeout_no_out", vcnt, 0);
    in_valid = 1'b1;
    in_data  = 32'h0000_0400;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("error_cleared", error, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
